// File: rtl/common_crc_pkg.sv
// Shared FSM type and helpers for the streaming CRC engine.
package common_crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } crc_state_e;

  localparam int unsigned CRC_MAX_W = 64;

  // Reverses the low 'width' bits; bits above 'width' come back zero.
  function automatic logic [CRC_MAX_W-1:0] bit_reverse(input logic [CRC_MAX_W-1:0] value,
                                                       input int unsigned width);
    logic [CRC_MAX_W-1:0] r;
    logic [CRC_MAX_W-1:0] v;
    r = '0;
    v = value;
    for (int unsigned i = 0; i < CRC_MAX_W; i++) begin
      if (i < width) begin
        r = {r[CRC_MAX_W-2:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

  function automatic int unsigned lane_count_w(input int unsigned data_w);
    return (data_w > 8) ? $clog2(data_w / 8) : 1;
  endfunction

endpackage

// File: rtl/common_crc_stream_if.sv
// Beat stream and result handshake bundle for common_crc_stream.
interface common_crc_stream_if
  import common_crc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CRC_W  = 32
) ();
  localparam int unsigned LANE_W = lane_count_w(DATA_W);

  logic              s_valid_i;
  logic              s_ready_o;
  logic [DATA_W-1:0] s_data_i;
  logic              s_last_i;
  logic [LANE_W-1:0] s_bytes_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [CRC_W-1:0]  res_crc_o;
  logic              res_ok_o;

  modport master (
    output s_valid_i, s_data_i, s_last_i, s_bytes_i, res_ready_i,
    input  s_ready_o, res_valid_o, res_crc_o, res_ok_o
  );

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, s_bytes_i, res_ready_i,
    output s_ready_o, res_valid_o, res_crc_o, res_ok_o
  );
endinterface

// File: rtl/common_crc.sv
// Combinational CRC update over one DATA_W-bit chunk (one byte lane),
// feeding bits LSB first when FEED_LSB is set.
module common_crc #(
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      CRC_W    = 32,
  parameter logic [CRC_W-1:0] POLYNOM  = 32'h04C11DB7,
  parameter bit               FEED_LSB = 1'b1
) (
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  always_comb begin
    logic [CRC_W-1:0]  c;
    logic [DATA_W-1:0] d;
    logic              fb;
    c  = crc_i;
    d  = data_i;
    fb = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb = c[CRC_W-1] ^ (FEED_LSB ? d[0] : d[DATA_W-1]);
      c  = (c << 1) ^ (fb ? POLYNOM : '0);
      d  = FEED_LSB ? (d >> 1) : (d << 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/common_crc_stream.sv
// Handshaked CRC engine: one beat per cycle, partial last beat, residue check.
// One frame in flight; the result is held until consumed.
module common_crc_stream
  import common_crc_pkg::*;
#(
  parameter int unsigned      DATA_W      = 32,
  parameter int unsigned      CRC_W       = 32,
  parameter logic [CRC_W-1:0] POLYNOM     = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT        = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT     = 32'hFFFFFFFF,
  parameter bit               REFLECT_IN  = 1'b1,
  parameter bit               REFLECT_OUT = 1'b1,
  parameter logic [CRC_W-1:0] CHECK       = 32'h2144DF1C
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  common_crc_stream_if.slave  bus,
  output logic                busy_o
);

  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned LANE_W = lane_count_w(DATA_W);

  crc_state_e       state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] crc_final;
  logic [CRC_W-1:0] lane_out [LANES];
  logic             beat_fire;
  logic             res_fire;

  // Lane k output is the CRC after bytes 0..k; each lane gets its own
  // generate-scope nets so the chain is not one self-referencing array.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CRC_W-1:0] crc_in;
    logic [CRC_W-1:0] crc_out;
    if (k == 0) begin : g_first
      assign crc_in = crc_q;
    end else begin : g_next
      assign crc_in = g_lane[k-1].crc_out;
    end
    common_crc #(
      .DATA_W   (8),
      .CRC_W    (CRC_W),
      .POLYNOM  (POLYNOM),
      .FEED_LSB (REFLECT_IN)
    ) u_step (
      .crc_i  (crc_in),
      .data_i (bus.s_data_i[8*k +: 8]),
      .crc_o  (crc_out)
    );
    assign lane_out[k] = crc_out;
  end

  if (LANES == 1) begin : g_mux1
    logic unused_bytes;
    assign unused_bytes = ^bus.s_bytes_i;
    assign crc_next     = lane_out[0];
  end else begin : g_muxn
    logic [LANE_W-1:0] sel;
    always_comb begin
      sel = LANE_W'(LANES - 1);
      if (bus.s_last_i && (bus.s_bytes_i != '0)) begin
        sel = bus.s_bytes_i - 1'b1;
      end
    end
    assign crc_next = lane_out[sel];
  end

  always_comb begin
    crc_final = REFLECT_OUT ? CRC_W'(bit_reverse(CRC_MAX_W'(crc_next), CRC_W)) : crc_next;
    crc_final = crc_final ^ XOR_OUT;
  end

  assign bus.s_ready_o   = (state_q != DONE);
  assign bus.res_valid_o = (state_q == DONE);
  assign busy_o          = (state_q != IDLE);
  assign beat_fire       = bus.s_valid_i && bus.s_ready_o;
  assign res_fire        = bus.res_valid_o && bus.res_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      crc_q         <= INIT;
      bus.res_crc_o <= '0;
      bus.res_ok_o  <= 1'b0;
    end else if (clear_i) begin
      state_q       <= IDLE;
      crc_q         <= INIT;
      bus.res_crc_o <= '0;
      bus.res_ok_o  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACC: begin
          if (beat_fire) begin
            crc_q <= crc_next;
            if (bus.s_last_i) begin
              state_q       <= DONE;
              bus.res_crc_o <= crc_final;
              bus.res_ok_o  <= (crc_final == CHECK);
            end else begin
              state_q <= ACC;
            end
          end
        end
        DONE: begin
          if (res_fire) begin
            state_q <= IDLE;
            crc_q   <= INIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_common_crc_stream.sv
// Bench for common_crc_stream: 32-bit CRC-32 instance plus byte-wide CRC-32
// and CRC-8 instances sharing one stimulus stream.
module tb_common_crc_stream;

  typedef logic [7:0] bytes_t[$];

  typedef struct {
    int unsigned      nbeats;
    logic [3:0][31:0] beats;
    logic [1:0]       last_bytes;
    bit               chk_const;
    logic [31:0]      exp_crc;
    logic             exp_ok;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr0, clr1;
  logic       busy0, busy1, busy2;
  logic       b_valid, b_last, b_rready, b_bytes;
  logic [7:0] b_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bytes_t      digits;
  vec_t        vecs[$];

  common_crc_stream_if #(.DATA_W(32), .CRC_W(32)) bus0 ();
  common_crc_stream_if #(.DATA_W(8),  .CRC_W(32)) bus1 ();
  common_crc_stream_if #(.DATA_W(8),  .CRC_W(8))  bus2 ();

  assign bus1.s_valid_i   = b_valid;
  assign bus1.s_data_i    = b_data;
  assign bus1.s_last_i    = b_last;
  assign bus1.s_bytes_i   = b_bytes;
  assign bus1.res_ready_i = b_rready;
  assign bus2.s_valid_i   = b_valid;
  assign bus2.s_data_i    = b_data;
  assign bus2.s_last_i    = b_last;
  assign bus2.s_bytes_i   = b_bytes;
  assign bus2.res_ready_i = b_rready;

  common_crc_stream #(.DATA_W(32)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr0), .bus(bus0), .busy_o(busy0));

  common_crc_stream #(.DATA_W(8)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr1), .bus(bus1), .busy_o(busy1));

  common_crc_stream #(
    .DATA_W(8), .CRC_W(8), .POLYNOM(8'h07), .INIT(8'h00), .XOR_OUT(8'h00),
    .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .CHECK(8'h00)
  ) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr1), .bus(bus2), .busy_o(busy2));

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual timeout required handshake within 100 cycles", name);
  endtask

  // Serial model: flatten the frame into its wire bit order, divide bit by bit.
  function automatic logic [31:0] ref_crc(input bytes_t msg, input int unsigned w,
                                          input logic [31:0] poly, input logic [31:0] init,
                                          input logic [31:0] xo, input bit refin, input bit refout);
    logic [31:0] mask, crc, r;
    bit bits[$];
    bit top;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    foreach (msg[i])
      for (int j = 0; j < 8; j++) bits.push_back(refin ? msg[i][j] : msg[i][7-j]);
    crc = init & mask;
    foreach (bits[i]) begin
      top = crc[w-1] ^ bits[i];
      crc = (crc << 1) & mask;
      if (top) crc = crc ^ poly;
    end
    if (refout) begin
      r = '0;
      for (int unsigned i = 0; i < w; i++) r[i] = crc[w-1-i];
      crc = r;
    end
    return (crc ^ xo) & mask;
  endfunction

  function automatic logic [31:0] ref32(input bytes_t msg);
    return ref_crc(msg, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
  endfunction

  function automatic logic [31:0] ref8(input bytes_t msg);
    return ref_crc(msg, 8, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0);
  endfunction

  task automatic add_vec(input int unsigned nb, input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3, input logic [1:0] lb,
                         input bit cc, input logic [31:0] ec, input logic eo);
    vec_t v;
    v.nbeats = nb; v.beats = {b3, b2, b1, b0}; v.last_bytes = lb;
    v.chk_const = cc; v.exp_crc = ec; v.exp_ok = eo;
    vecs.push_back(v);
  endtask

  // All drive tasks start and end at a falling edge.
  task automatic beat0(input logic [31:0] data, input logic last, input logic [1:0] nb);
    int unsigned t = 0;
    bus0.s_valid_i = 1'b1; bus0.s_data_i = data; bus0.s_last_i = last; bus0.s_bytes_i = nb;
    while (!bus0.s_ready_o && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("beat0_ready");
    @(negedge clk);
    bus0.s_valid_i = 1'b0; bus0.s_data_i = $urandom;
    bus0.s_last_i = 1'($urandom); bus0.s_bytes_i = 2'($urandom);
  endtask

  task automatic send0(input bytes_t msg, input bit gaps);
    int unsigned n = msg.size();
    for (int unsigned i = 0; i < n; i += 4) begin
      logic [31:0] d;
      int unsigned rem;
      d = $urandom;
      rem = n - i;
      for (int unsigned j = 0; j < 4 && j < rem; j++) d[8*j +: 8] = msg[i+j];
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      beat0(d, rem <= 4, (rem >= 4) ? 2'd0 : 2'(rem));
    end
  endtask

  task automatic get0(output logic [31:0] crc, output logic ok, input int unsigned delay);
    int unsigned t = 0;
    repeat (delay) @(negedge clk);
    while (!bus0.res_valid_o && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("get0_valid");
    crc = bus0.res_crc_o; ok = bus0.res_ok_o;
    bus0.res_ready_i = 1'b1;
    @(negedge clk);
    bus0.res_ready_i = 1'b0;
  endtask

  task automatic frame0(input bytes_t msg, input bit gaps, input string name, output logic [31:0] crc);
    logic [31:0] e;
    logic ok;
    e = ref32(msg);
    send0(msg, gaps);
    check({name, "_valid_t1"}, bus0.res_valid_o, 1);
    get0(crc, ok, gaps ? $urandom_range(0, 3) : 0);
    check({name, "_crc"}, crc, e);
    check({name, "_ok"}, ok, e == 32'h2144DF1C);
    check({name, "_idle_after"}, {bus0.res_valid_o, bus0.s_ready_o}, 2'b01);
  endtask

  task automatic beat12(input logic [7:0] d, input logic last);
    int unsigned t = 0;
    b_valid = 1'b1; b_data = d; b_last = last; b_bytes = 1'($urandom);
    while (!bus1.s_ready_o && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) timeout("beat12_ready");
    @(negedge clk);
    b_valid = 1'b0; b_data = 8'($urandom); b_last = 1'($urandom);
  endtask

  task automatic frame12(input bytes_t msg, input string name,
                         output logic [31:0] c1, output logic [7:0] c2);
    logic [31:0] e1;
    logic [7:0]  e2;
    e1 = ref32(msg);
    e2 = 8'(ref8(msg));
    foreach (msg[i]) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      beat12(msg[i], i == msg.size() - 1);
    end
    check({name, "_valid1_t1"}, bus1.res_valid_o, 1);
    check({name, "_valid2_t1"}, bus2.res_valid_o, 1);
    c1 = bus1.res_crc_o; c2 = bus2.res_crc_o;
    check({name, "_crc32"}, c1, e1);
    check({name, "_ok32"}, bus1.res_ok_o, e1 == 32'h2144DF1C);
    check({name, "_crc8"}, c2, e2);
    check({name, "_ok8"}, bus2.res_ok_o, e2 == 8'h00);
    b_rready = 1'b1;
    @(negedge clk);
    b_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] c, e;
    logic [7:0]  c8;
    logic        ok;
    bytes_t      m;

    digits = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst_n = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    bus0.s_valid_i = 1'b0; bus0.s_data_i = '0; bus0.s_last_i = 1'b0;
    bus0.s_bytes_i = '0; bus0.res_ready_i = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_bytes = 1'b0; b_rready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ready", bus0.s_ready_o, 1);
    check("rst_res_valid", bus0.res_valid_o, 0);
    check("rst_res_crc", bus0.res_crc_o, 0);
    check("rst_res_ok", bus0.res_ok_o, 0);
    check("rst_busy", busy0, 0);
    check("rst_crc8", bus2.res_crc_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: {beats, last-beat lane count, expected CRC, expected residue flag}
    add_vec(3, 32'h34333231, 32'h38373635, 32'h00000039, 0, 2'd1, 1, 32'hCBF43926, 1'b0);
    add_vec(3, 32'h34333231, 32'h38373635, 32'hAABBCC39, 0, 2'd1, 1, 32'hCBF43926, 1'b0);
    add_vec(4, 32'h34333231, 32'h38373635, 32'hF4392639, 32'h000000CB, 2'd1, 1, 32'h2144DF1C, 1'b1);
    add_vec(4, 32'h34333230, 32'h38373635, 32'hF4392639, 32'h000000CB, 2'd1, 0, 32'h0, 1'b0);
    add_vec(1, 32'h34333231, 0, 0, 0, 2'd0, 0, 32'h0, 1'b0);
    add_vec(1, 32'hDEADBE31, 0, 0, 0, 2'd1, 0, 32'h0, 1'b0);
    add_vec(2, 32'h34333231, 32'h55373635, 0, 0, 2'd3, 0, 32'h0, 1'b0);
    add_vec(2, 32'h34333231, 32'h38373635, 0, 0, 2'd0, 0, 32'h0, 1'b0);

    for (int pass = 0; pass < 2; pass++) begin
      foreach (vecs[i]) begin
        string nm;
        nm = $sformatf("vec%0d_p%0d", i, pass);
        m = {};
        for (int unsigned b = 0; b < vecs[i].nbeats; b++) begin
          logic last;
          int unsigned nl;
          last = (b == vecs[i].nbeats - 1);
          nl = (last && vecs[i].last_bytes != 0) ? vecs[i].last_bytes : 4;
          for (int unsigned j = 0; j < nl; j++) m.push_back(vecs[i].beats[b][8*j +: 8]);
          if (pass == 1) repeat ($urandom_range(0, 2)) @(negedge clk);
          beat0(vecs[i].beats[b], last, last ? vecs[i].last_bytes : 2'($urandom_range(1, 3)));
          if (!last) check({nm, "_busy"}, busy0, 1);
        end
        check({nm, "_valid_t1"}, bus0.res_valid_o, 1);
        get0(c, ok, pass == 1 ? $urandom_range(0, 3) : 0);
        check({nm, "_crc_model"}, c, ref32(m));
        if (vecs[i].chk_const) check({nm, "_crc_const"}, c, vecs[i].exp_crc);
        check({nm, "_ok"}, ok, vecs[i].exp_ok);
      end
    end

    // Result held with beats offered: nothing may be consumed.
    send0(digits, 0);
    for (int k = 0; k < 5; k++) begin
      bus0.s_valid_i = 1'b1; bus0.s_data_i = 32'hDEADBEEF; bus0.s_last_i = 1'b0;
      @(negedge clk);
      check("hold_ready", bus0.s_ready_o, 0);
      check("hold_valid", bus0.res_valid_o, 1);
      check("hold_crc", bus0.res_crc_o, 32'hCBF43926);
    end
    bus0.s_valid_i = 1'b0;
    get0(c, ok, 0);
    check("hold_release_crc", c, 32'hCBF43926);
    frame0(digits, 0, "after_hold", c);

    // Clear mid-frame together with an offered last beat.
    beat0(32'h34333231, 1'b0, 2'd2);
    check("clr_busy_before", busy0, 1);
    clr0 = 1'b1;
    bus0.s_valid_i = 1'b1; bus0.s_data_i = 32'h38373635; bus0.s_last_i = 1'b1; bus0.s_bytes_i = 2'd0;
    @(negedge clk);
    clr0 = 1'b0; bus0.s_valid_i = 1'b0;
    check("clr_busy", busy0, 0);
    check("clr_res_valid", bus0.res_valid_o, 0);
    check("clr_ready", bus0.s_ready_o, 1);
    frame0(digits, 0, "after_clr", c);
    check("after_clr_const", c, 32'hCBF43926);

    // Clear wins over a simultaneous result handshake.
    send0(digits, 0);
    clr0 = 1'b1; bus0.res_ready_i = 1'b1;
    @(negedge clk);
    clr0 = 1'b0; bus0.res_ready_i = 1'b0;
    check("clr_done_valid", bus0.res_valid_o, 0);
    check("clr_done_busy", busy0, 0);
    frame0(digits, 1, "after_clr_done", c);

    // Async reset with a result pending, then mid-frame.
    send0(digits, 0);
    rst_n = 1'b0;
    #1;
    check("arst_done_ready", bus0.s_ready_o, 1);
    check("arst_done_valid", bus0.res_valid_o, 0);
    check("arst_done_crc", bus0.res_crc_o, 0);
    check("arst_done_ok", bus0.res_ok_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat0(32'h34333231, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    check("arst_mid_busy", busy0, 0);
    check("arst_mid_ready", bus0.s_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame0(digits, 0, "after_arst", c);
    check("after_arst_const", c, 32'hCBF43926);

    // Randomized frames, a third of them carrying their own CRC appended.
    for (int f = 0; f < 40; f++) begin
      int unsigned len;
      m = {};
      len = $urandom_range(1, 24);
      for (int unsigned j = 0; j < len; j++) m.push_back(8'($urandom));
      if (f % 3 == 0) begin
        e = ref32(m);
        m.push_back(e[7:0]); m.push_back(e[15:8]); m.push_back(e[23:16]); m.push_back(e[31:24]);
      end
      frame0(m, 1, $sformatf("rand%0d", f), c);
    end

    // Byte-wide instances: CRC-32 and CRC-8 on the same stream.
    frame12(digits, "w8_digits", c, c8);
    check("w8_crc32_const", c, 32'hCBF43926);
    check("w8_crc8_const", c8, 8'hF4);
    m = digits;
    m.push_back(8'h26); m.push_back(8'h39); m.push_back(8'hF4); m.push_back(8'hCB);
    frame12(m, "w8_residue32", c, c8);
    check("w8_residue32_ok", bus1.res_ok_o, 1);
    m = digits;
    m.push_back(8'hF4);
    frame12(m, "w8_residue8", c, c8);
    check("w8_residue8_ok", bus2.res_ok_o, 1);
    check("w8_residue8_crc", c8, 8'h00);
    for (int f = 0; f < 8; f++) begin
      int unsigned len;
      m = {};
      len = $urandom_range(1, 12);
      for (int unsigned j = 0; j < len; j++) m.push_back(8'($urandom));
      frame12(m, $sformatf("w8_rand%0d", f), c, c8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
